// File: rtl/i2s_transmitter_pkg.sv
// Shared types and constants for the I2S transmitter: the mixer sample type,
// default slot/clock settings and the slot-position to serial-bit mapping.
package i2s_transmitter_pkg;

    localparam int SAMPLE_WIDTH   = 24;
    localparam int SLOT_WIDTH_DEF = 32;
    localparam int BCLK_DIV_DEF   = 4;
    localparam int SAMPLE_IDX_W   = $clog2(SAMPLE_WIDTH);

    typedef logic [SAMPLE_WIDTH-1:0] sample_t;

    // Slot position 0 is the I2S one-bit delay; positions 1..SAMPLE_WIDTH carry
    // the sample MSB first; anything after that pads with zero.
    function automatic logic slot_bit(input sample_t frame, input int pos);
        logic [SAMPLE_IDX_W-1:0] idx;
        idx = SAMPLE_IDX_W'(SAMPLE_WIDTH - pos);
        if (pos >= 1 && pos <= SAMPLE_WIDTH) begin
            return frame[idx];
        end
        return 1'b0;
    endfunction

endpackage

// File: rtl/i2s_transmitter_bclk_gen.sv
// Bit-clock generator: divides the system clock into BCLK and flags the
// cycles in which BCLK is about to rise or fall.
module i2s_transmitter_bclk_gen #(
    parameter int BCLK_DIV = 4
) (
    input  logic clock,
    input  logic reset_l,
    output logic bclk,
    output logic fall_event,
    output logic rise_event
);

    localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             bclk_q, bclk_d;
    logic             term_cnt;

    always_comb begin
        term_cnt   = (div_cnt_q == DIV_LAST);
        div_cnt_d  = term_cnt ? '0 : div_cnt_q + DIV_W'(1);
        bclk_d     = term_cnt ? ~bclk_q : bclk_q;
        // Events mark the cycle whose closing edge toggles bclk, so logic
        // registered on them changes together with the bclk edge.
        fall_event = term_cnt & bclk_q;
        rise_event = term_cnt & ~bclk_q;
    end

    always_ff @(posedge clock) begin
        if (!reset_l) begin
            div_cnt_q <= '0;
            bclk_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            bclk_q    <= bclk_d;
        end
    end

    assign bclk = bclk_q;

endmodule

// File: rtl/i2s_transmitter.sv
// Philips I2S transmitter: buffers one mixer sample and sends it MSB first
// on both the left and right slots of every frame.
module i2s_transmitter
    import i2s_transmitter_pkg::*;
#(
    parameter int SLOT_WIDTH = SLOT_WIDTH_DEF,
    parameter int BCLK_DIV   = BCLK_DIV_DEF
) (
    input  logic    clock,
    input  logic    reset_l,
    input  sample_t sample_in,
    input  logic    sample_valid,
    output logic    sample_ready,
    output logic    bclk,
    output logic    lrclk,
    output logic    sdata,
    output logic    frame_start,
    output logic    underrun
);

    localparam int BIT_W = $clog2(2 * SLOT_WIDTH);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(2 * SLOT_WIDTH - 1);
    localparam logic [BIT_W-1:0] SLOT_LIM = BIT_W'(SLOT_WIDTH);

    logic             fall_event;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    sample_t          holding_q, holding_d;
    sample_t          frame_q, frame_d;
    logic             holding_full_q, holding_full_d;
    logic             sample_ready_q, sample_ready_d;
    logic             lrclk_q, lrclk_d;
    logic             sdata_q, sdata_d;
    logic             frame_start_q, frame_start_d;
    logic             underrun_q, underrun_d;
    logic             accept, load;
    int               pos;

    i2s_transmitter_bclk_gen #(
        .BCLK_DIV (BCLK_DIV)
    ) u_bclk_gen (
        .clock      (clock),
        .reset_l    (reset_l),
        .bclk       (bclk),
        .fall_event (fall_event),
        .rise_event ()
    );

    always_comb begin
        accept         = sample_valid & sample_ready_q;
        load           = fall_event && (bit_cnt_q == LAST_BIT);
        bit_cnt_d      = bit_cnt_q;
        holding_d      = holding_q;
        holding_full_d = holding_full_q;
        frame_d        = frame_q;

        if (fall_event) begin
            bit_cnt_d = load ? '0 : bit_cnt_q + BIT_W'(1);
        end
        // An empty holding register at load time leaves frame_q as is, so
        // the previous sample repeats. There is no bypass from sample_in.
        if (load && holding_full_q) begin
            frame_d        = holding_q;
            holding_full_d = 1'b0;
        end
        if (accept) begin
            holding_d      = sample_in;
            holding_full_d = 1'b1;
        end

        sample_ready_d = ~holding_full_d;
        frame_start_d  = load;
        underrun_d     = load & ~holding_full_q;

        if (bit_cnt_d >= SLOT_LIM) begin
            pos = int'(bit_cnt_d) - SLOT_WIDTH;
        end else begin
            pos = int'(bit_cnt_d);
        end
        lrclk_d = (bit_cnt_d >= SLOT_LIM);
        sdata_d = slot_bit(frame_d, pos);
    end

    always_ff @(posedge clock) begin
        if (!reset_l) begin
            bit_cnt_q      <= '0;
            holding_q      <= '0;
            frame_q        <= '0;
            holding_full_q <= 1'b0;
            sample_ready_q <= 1'b1;
            lrclk_q        <= 1'b0;
            sdata_q        <= 1'b0;
            frame_start_q  <= 1'b0;
            underrun_q     <= 1'b0;
        end else begin
            bit_cnt_q      <= bit_cnt_d;
            holding_q      <= holding_d;
            frame_q        <= frame_d;
            holding_full_q <= holding_full_d;
            sample_ready_q <= sample_ready_d;
            lrclk_q        <= lrclk_d;
            sdata_q        <= sdata_d;
            frame_start_q  <= frame_start_d;
            underrun_q     <= underrun_d;
        end
    end

    assign sample_ready = sample_ready_q;
    assign lrclk        = lrclk_q;
    assign sdata        = sdata_q;
    assign frame_start  = frame_start_q;
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_i2s_transmitter.sv
// Directed bench for i2s_transmitter with default settings: 8-clock BCLK,
// 32-bit slots, 24-bit samples.
module tb_i2s_transmitter;
    import i2s_transmitter_pkg::*;

    logic    clock = 1'b0;
    logic    reset_l = 1'b0;
    sample_t sample_in = '0;
    logic    sample_valid = 1'b0;
    logic    sample_ready, bclk, lrclk, sdata, frame_start, underrun;

    int vectors = 0;
    int miscompares = 0;

    // Results of the most recent frame capture
    logic [31:0] cap_left, cap_right;
    int cap_bclk_err, cap_lr_err, cap_stab_err, cap_fs_cnt, cap_ur_cnt;

    always #5 clock = ~clock;

    i2s_transmitter dut (
        .clock        (clock),
        .reset_l      (reset_l),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .bclk         (bclk),
        .lrclk        (lrclk),
        .sdata        (sdata),
        .frame_start  (frame_start),
        .underrun     (underrun)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    // Called on the negedge where frame_start is high; records 64 bit periods
    // (8 clocks each) and returns on the negedge of the next frame start.
    task automatic capture_frame();
        logic sd0;
        sd0          = 1'b0;
        cap_left     = '0;
        cap_right    = '0;
        cap_bclk_err = 0;
        cap_lr_err   = 0;
        cap_stab_err = 0;
        cap_fs_cnt   = 0;
        cap_ur_cnt   = 0;
        for (int b = 0; b < 64; b++) begin
            for (int k = 0; k < 8; k++) begin
                if (bclk !== (k >= 4)) cap_bclk_err++;
                if (lrclk !== (b >= 32)) cap_lr_err++;
                if (k == 0) sd0 = sdata;
                else if (sdata !== sd0) cap_stab_err++;
                if (frame_start === 1'b1) cap_fs_cnt++;
                if (underrun === 1'b1) cap_ur_cnt++;
                @(negedge clock);
            end
            if (b < 32) cap_left = {cap_left[30:0], sd0};
            else        cap_right = {cap_right[30:0], sd0};
        end
    endtask

    task automatic wait_frame_start(output int cycles);
        cycles = 0;
        while (frame_start !== 1'b1 && cycles < 600) begin
            @(negedge clock);
            cycles++;
        end
        vectors++;
        if (frame_start !== 1'b1) begin
            miscompares++;
            $display("FAIL frame_start_timeout: got no frame_start in %0d cycles, required within 600", cycles);
        end
    endtask

    task automatic test_reset();
        reset_l      = 1'b0;
        sample_valid = 1'b0;
        sample_in    = '0;
        repeat (3) @(negedge clock);
        vectors += 6;
        if (bclk !== 1'b0) begin miscompares++; $display("FAIL reset_bclk: got %b expected 0", bclk); end
        if (lrclk !== 1'b0) begin miscompares++; $display("FAIL reset_lrclk: got %b expected 0", lrclk); end
        if (sdata !== 1'b0) begin miscompares++; $display("FAIL reset_sdata: got %b expected 0", sdata); end
        if (frame_start !== 1'b0) begin miscompares++; $display("FAIL reset_frame_start: got %b expected 0", frame_start); end
        if (underrun !== 1'b0) begin miscompares++; $display("FAIL reset_underrun: got %b expected 0", underrun); end
        if (sample_ready !== 1'b1) begin miscompares++; $display("FAIL reset_sample_ready: got %b expected 1", sample_ready); end
    endtask

    task automatic test_first_frame();
        int cnt;
        int nonzero;
        cnt     = 0;
        nonzero = 0;
        reset_l = 1'b1;
        while (frame_start !== 1'b1 && cnt < 600) begin
            @(negedge clock);
            cnt++;
            if (sdata !== 1'b0) nonzero++;
        end
        vectors += 4;
        if (cnt !== 512) begin miscompares++; $display("FAIL first_load_latency: got %0d cycles expected 512", cnt); end
        if (nonzero !== 0) begin miscompares++; $display("FAIL first_frame_zeros: got %0d nonzero cycles expected 0", nonzero); end
        if (underrun !== 1'b1) begin miscompares++; $display("FAIL first_underrun: got %b expected 1", underrun); end
        if (sample_ready !== 1'b1) begin miscompares++; $display("FAIL first_ready: got %b expected 1", sample_ready); end
        // Empty frame after the first load: checks BCLK/LRCLK shape and zero data
        capture_frame();
        vectors += 6;
        if (cap_left !== 32'h0) begin miscompares++; $display("FAIL empty_left: got %h expected 00000000", cap_left); end
        if (cap_right !== 32'h0) begin miscompares++; $display("FAIL empty_right: got %h expected 00000000", cap_right); end
        if (cap_bclk_err !== 0) begin miscompares++; $display("FAIL bclk_shape: got %0d bad cycles expected 0", cap_bclk_err); end
        if (cap_lr_err !== 0) begin miscompares++; $display("FAIL lrclk_shape: got %0d bad cycles expected 0", cap_lr_err); end
        if (cap_stab_err !== 0) begin miscompares++; $display("FAIL sdata_stability: got %0d mid-bit changes expected 0", cap_stab_err); end
        if (cap_fs_cnt !== 1) begin miscompares++; $display("FAIL frame_start_pulses: got %0d expected 1", cap_fs_cnt); end
    endtask

    task automatic test_single_sample();
        int cyc;
        vectors += 2;
        if (underrun !== 1'b1) begin miscompares++; $display("FAIL single_pre_underrun: got %b expected 1", underrun); end
        if (sample_ready !== 1'b1) begin miscompares++; $display("FAIL single_pre_ready: got %b expected 1", sample_ready); end
        sample_valid = 1'b1;
        sample_in    = 24'h3FFFFF;
        @(negedge clock);
        sample_valid = 1'b0;
        sample_in    = '0;
        vectors++;
        if (sample_ready !== 1'b0) begin miscompares++; $display("FAIL single_ready_drop: got %b expected 0", sample_ready); end
        wait_frame_start(cyc);
        vectors += 2;
        if (sample_ready !== 1'b1) begin miscompares++; $display("FAIL single_ready_return: got %b expected 1", sample_ready); end
        if (underrun !== 1'b0) begin miscompares++; $display("FAIL single_underrun: got %b expected 0", underrun); end
        capture_frame();
        vectors += 5;
        if (cap_left !== 32'h1FFFFF80) begin miscompares++; $display("FAIL single_left: got %h expected 1fffff80", cap_left); end
        if (cap_right !== 32'h1FFFFF80) begin miscompares++; $display("FAIL single_right: got %h expected 1fffff80", cap_right); end
        if (cap_left !== cap_right) begin miscompares++; $display("FAIL single_lr_equal: left %h right %h expected equal", cap_left, cap_right); end
        if (cap_stab_err !== 0) begin miscompares++; $display("FAIL single_stability: got %0d mid-bit changes expected 0", cap_stab_err); end
        if (cap_lr_err !== 0) begin miscompares++; $display("FAIL single_lrclk: got %0d bad cycles expected 0", cap_lr_err); end
    endtask

    task automatic test_pattern();
        int cyc;
        vectors++;
        if (underrun !== 1'b1) begin miscompares++; $display("FAIL pattern_pre_underrun: got %b expected 1", underrun); end
        sample_valid = 1'b1;
        sample_in    = 24'h000003;
        @(negedge clock);
        sample_valid = 1'b0;
        sample_in    = '0;
        wait_frame_start(cyc);
        vectors++;
        if (underrun !== 1'b0) begin miscompares++; $display("FAIL pattern_underrun: got %b expected 0", underrun); end
        capture_frame();
        vectors += 2;
        if (cap_left !== 32'h00000180) begin miscompares++; $display("FAIL pattern_left: got %h expected 00000180", cap_left); end
        if (cap_right !== 32'h00000180) begin miscompares++; $display("FAIL pattern_right: got %h expected 00000180", cap_right); end
        // No new sample: the same pattern repeats with one underrun pulse
        capture_frame();
        vectors += 4;
        if (cap_left !== 32'h00000180) begin miscompares++; $display("FAIL repeat_left: got %h expected 00000180", cap_left); end
        if (cap_right !== 32'h00000180) begin miscompares++; $display("FAIL repeat_right: got %h expected 00000180", cap_right); end
        if (cap_ur_cnt !== 1) begin miscompares++; $display("FAIL repeat_underrun_pulses: got %0d expected 1", cap_ur_cnt); end
        if (cap_fs_cnt !== 1) begin miscompares++; $display("FAIL repeat_frame_start_pulses: got %0d expected 1", cap_fs_cnt); end
    endtask

    task automatic test_back_to_back();
        int   cyc;
        logic ready_after;
        ready_after  = 1'b1;
        sample_valid = 1'b1;
        sample_in    = 24'h00000F;
        @(negedge clock);
        vectors++;
        if (sample_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_ready_drop: got %b expected 0", sample_ready); end
        sample_in = 24'hABCDEF;
        wait_frame_start(cyc);
        vectors += 2;
        if (sample_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready_return: got %b expected 1", sample_ready); end
        if (underrun !== 1'b0) begin miscompares++; $display("FAIL b2b_underrun1: got %b expected 0", underrun); end
        sample_in = 24'h000001;
        fork
            capture_frame();
            begin
                @(negedge clock);
                ready_after = sample_ready;
                sample_in   = 24'h123456;
            end
        join
        sample_valid = 1'b0;
        vectors += 4;
        if (ready_after !== 1'b0) begin miscompares++; $display("FAIL b2b_one_per_frame: got ready %b expected 0", ready_after); end
        if (cap_left !== 32'h00000780) begin miscompares++; $display("FAIL b2b_first_left: got %h expected 00000780", cap_left); end
        if (cap_right !== 32'h00000780) begin miscompares++; $display("FAIL b2b_first_right: got %h expected 00000780", cap_right); end
        if (underrun !== 1'b0) begin miscompares++; $display("FAIL b2b_underrun2: got %b expected 0", underrun); end
        capture_frame();
        vectors += 3;
        if (cap_left !== 32'h00000080) begin miscompares++; $display("FAIL b2b_second_left: got %h expected 00000080", cap_left); end
        if (cap_right !== 32'h00000080) begin miscompares++; $display("FAIL b2b_second_right: got %h expected 00000080", cap_right); end
        if (underrun !== 1'b1) begin miscompares++; $display("FAIL b2b_final_underrun: got %b expected 1", underrun); end
    endtask

    task automatic test_collision();
        repeat (511) @(negedge clock);
        vectors++;
        if (frame_start !== 1'b0) begin miscompares++; $display("FAIL coll_pre_frame_start: got %b expected 0", frame_start); end
        sample_valid = 1'b1;
        sample_in    = 24'h800001;
        @(negedge clock);
        sample_valid = 1'b0;
        sample_in    = '0;
        vectors += 3;
        if (frame_start !== 1'b1) begin miscompares++; $display("FAIL coll_frame_start: got %b expected 1", frame_start); end
        if (underrun !== 1'b1) begin miscompares++; $display("FAIL coll_underrun: got %b expected 1", underrun); end
        if (sample_ready !== 1'b0) begin miscompares++; $display("FAIL coll_captured: got ready %b expected 0", sample_ready); end
        capture_frame();
        vectors += 4;
        if (cap_left !== 32'h00000080) begin miscompares++; $display("FAIL coll_no_bypass: got %h expected 00000080", cap_left); end
        if (cap_right !== 32'h00000080) begin miscompares++; $display("FAIL coll_no_bypass_right: got %h expected 00000080", cap_right); end
        if (underrun !== 1'b0) begin miscompares++; $display("FAIL coll_next_underrun: got %b expected 0", underrun); end
        if (sample_ready !== 1'b1) begin miscompares++; $display("FAIL coll_next_ready: got %b expected 1", sample_ready); end
        capture_frame();
        vectors += 2;
        if (cap_left !== 32'h40000080) begin miscompares++; $display("FAIL coll_next_left: got %h expected 40000080", cap_left); end
        if (cap_right !== 32'h40000080) begin miscompares++; $display("FAIL coll_next_right: got %h expected 40000080", cap_right); end
    endtask

    task automatic test_reset_mid_frame();
        int cnt;
        sample_valid = 1'b1;
        sample_in    = 24'hFFFFFF;
        @(negedge clock);
        sample_valid = 1'b0;
        sample_in    = '0;
        // 326 cycles past frame start: bit 40, bclk high phase
        repeat (325) @(negedge clock);
        vectors += 3;
        if (lrclk !== 1'b1) begin miscompares++; $display("FAIL mid_lrclk: got %b expected 1", lrclk); end
        if (bclk !== 1'b1) begin miscompares++; $display("FAIL mid_bclk: got %b expected 1", bclk); end
        if (sample_ready !== 1'b0) begin miscompares++; $display("FAIL mid_ready: got %b expected 0", sample_ready); end
        reset_l = 1'b0;
        @(negedge clock);
        vectors += 6;
        if (bclk !== 1'b0) begin miscompares++; $display("FAIL midrst_bclk: got %b expected 0", bclk); end
        if (lrclk !== 1'b0) begin miscompares++; $display("FAIL midrst_lrclk: got %b expected 0", lrclk); end
        if (sdata !== 1'b0) begin miscompares++; $display("FAIL midrst_sdata: got %b expected 0", sdata); end
        if (frame_start !== 1'b0) begin miscompares++; $display("FAIL midrst_frame_start: got %b expected 0", frame_start); end
        if (underrun !== 1'b0) begin miscompares++; $display("FAIL midrst_underrun: got %b expected 0", underrun); end
        if (sample_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_ready: got %b expected 1", sample_ready); end
        repeat (2) @(negedge clock);
        reset_l = 1'b1;
        cnt = 0;
        while (frame_start !== 1'b1 && cnt < 600) begin
            @(negedge clock);
            cnt++;
        end
        vectors += 4;
        if (cnt !== 512) begin miscompares++; $display("FAIL rerst_latency: got %0d cycles expected 512", cnt); end
        if (underrun !== 1'b1) begin miscompares++; $display("FAIL rerst_underrun: got %b expected 1", underrun); end
        capture_frame();
        if (cap_left !== 32'h0) begin miscompares++; $display("FAIL rerst_left_cleared: got %h expected 00000000", cap_left); end
        if (cap_right !== 32'h0) begin miscompares++; $display("FAIL rerst_right_cleared: got %h expected 00000000", cap_right); end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_single_sample();
        test_pattern();
        test_back_to_back();
        test_collision();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
